mesh_vlink_buffer: RTL and testbench

// - Registered vertical link stage between two mesh rows, one instance per column.
// - Carries both vertical directions: south->north (SN) and north->south (NS).
//   - SN: lower router snso/sndo to upper router snsi/sndi.
//   - NS: upper router nsso/nsdo to lower router nssi/nsdi.
// - Each direction has an independent DEPTH-entry FIFO. It decouples router timing and absorbs backpressure.
// - Packet-transparent: the VC/polarity bits and all other fields pass through unmodified.

---
 rtl/mesh_vlink_buffer.sv | 178 +++++++++++++++++
 tb/tb_mesh_vlink_buffer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_vlink_buffer.sv
// mesh_vlink_buffer: registered vertical link stage between two mesh rows.
// Two independent DEPTH-entry FIFOs, one per vertical direction:
//   SN: lower router -> upper router, NS: upper router -> lower router.
// Packets pass through untouched (VC/polarity bits included).
// Optional statistics counters are built only when VLINK_STATS_EN is defined;
// otherwise the counter outputs are tied to zero and the datapath is unchanged.
//
// Handshake (both directions, both sides):
//   A push happens at a clock edge where si && ri. ri depends only on the
//   registered occupancy, so it never reacts combinationally to si or ro.
//   A pop happens at a clock edge where the FIFO held a packet before the edge
//   and ro is high; the packet appears registered on so/do for exactly one
//   cycle after that edge. si while ri is low is a protocol violation: the
//   packet is discarded and counted as a drop.

module mesh_vlink_fifo #(
    parameter int PACKET_WIDTH = 64,
    parameter int DEPTH        = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    si,
    output logic                    ri,
    input  logic [PACKET_WIDTH-1:0] wdata,
    output logic                    so,
    input  logic                    ro,
    output logic [PACKET_WIDTH-1:0] rdata,
    output logic                    pop,
    output logic                    drop
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [PACKET_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        wr_ptr;
    logic [OCC_W-1:0]        count;
    logic                    push;

    // Ready comes from the registered occupancy only: a full FIFO stays not-ready
    // even in a cycle where it pops.
    assign ri   = (count < OCC_W'(DEPTH));
    assign push = si && ri;
    assign pop  = (count != '0) && ro;
    assign drop = si && !ri;

    // Packet storage; contents need no reset because occupancy guards every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; power-of-two DEPTH lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered output: one-cycle so pulse per popped packet, data held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            so    <= 1'b0;
            rdata <= '0;
        end else begin
            so <= pop;
            if (pop) begin
                rdata <= mem[rd_ptr];
            end
        end
    end

endmodule

module mesh_vlink_buffer #(
    parameter int PACKET_WIDTH = 64,
    parameter int DEPTH        = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sn_si,
    output logic                    sn_ri,
    input  logic [PACKET_WIDTH-1:0] sn_di,
    output logic                    sn_so,
    input  logic                    sn_ro,
    output logic [PACKET_WIDTH-1:0] sn_do,
    input  logic                    ns_si,
    output logic                    ns_ri,
    input  logic [PACKET_WIDTH-1:0] ns_di,
    output logic                    ns_so,
    input  logic                    ns_ro,
    output logic [PACKET_WIDTH-1:0] ns_do,
    output logic [CNT_WIDTH-1:0]    sn_pkt_cnt,
    output logic [CNT_WIDTH-1:0]    ns_pkt_cnt,
    output logic [CNT_WIDTH-1:0]    sn_drop_cnt,
    output logic [CNT_WIDTH-1:0]    ns_drop_cnt
);

    logic sn_pop;
    logic sn_drop;
    logic ns_pop;
    logic ns_drop;

    mesh_vlink_fifo #(
        .PACKET_WIDTH (PACKET_WIDTH),
        .DEPTH        (DEPTH)
    ) u_sn (
        .clk   (clk),
        .reset (reset),
        .si    (sn_si),
        .ri    (sn_ri),
        .wdata (sn_di),
        .so    (sn_so),
        .ro    (sn_ro),
        .rdata (sn_do),
        .pop   (sn_pop),
        .drop  (sn_drop)
    );

    mesh_vlink_fifo #(
        .PACKET_WIDTH (PACKET_WIDTH),
        .DEPTH        (DEPTH)
    ) u_ns (
        .clk   (clk),
        .reset (reset),
        .si    (ns_si),
        .ri    (ns_ri),
        .wdata (ns_di),
        .so    (ns_so),
        .ro    (ns_ro),
        .rdata (ns_do),
        .pop   (ns_pop),
        .drop  (ns_drop)
    );

`ifdef VLINK_STATS_EN
    // Statistics: a pop is counted at the same edge that raises so, so the
    // delivered count tracks so pulses exactly; counters wrap freely.
    always_ff @(posedge clk) begin
        if (reset) begin
            sn_pkt_cnt  <= '0;
            ns_pkt_cnt  <= '0;
            sn_drop_cnt <= '0;
            ns_drop_cnt <= '0;
        end else begin
            if (sn_pop)  sn_pkt_cnt  <= sn_pkt_cnt  + CNT_WIDTH'(1);
            if (ns_pop)  ns_pkt_cnt  <= ns_pkt_cnt  + CNT_WIDTH'(1);
            if (sn_drop) sn_drop_cnt <= sn_drop_cnt + CNT_WIDTH'(1);
            if (ns_drop) ns_drop_cnt <= ns_drop_cnt + CNT_WIDTH'(1);
        end
    end
`else
    logic unused_stats;
    assign unused_stats = sn_pop ^ sn_drop ^ ns_pop ^ ns_drop;
    assign sn_pkt_cnt   = '0;
    assign ns_pkt_cnt   = '0;
    assign sn_drop_cnt  = '0;
    assign ns_drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_mesh_vlink_buffer.sv
// Bench for mesh_vlink_buffer: directed scenarios followed by random traffic,
// all checked every cycle against a queue-based model of each direction.

module tb_mesh_vlink_buffer;

    localparam int PW    = 64;
    localparam int DEPTH = 2;
    localparam int CW    = 16;
`ifdef VLINK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          sn_si = 1'b0, sn_ro = 1'b0, ns_si = 1'b0, ns_ro = 1'b0;
    logic [PW-1:0] sn_di = '0, ns_di = '0;
    logic          sn_ri, sn_so, ns_ri, ns_so;
    logic [PW-1:0] sn_do, ns_do;
    logic [CW-1:0] sn_pkt_cnt, ns_pkt_cnt, sn_drop_cnt, ns_drop_cnt;

    mesh_vlink_buffer #(
        .PACKET_WIDTH (PW),
        .DEPTH        (DEPTH),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sn_si       (sn_si),
        .sn_ri       (sn_ri),
        .sn_di       (sn_di),
        .sn_so       (sn_so),
        .sn_ro       (sn_ro),
        .sn_do       (sn_do),
        .ns_si       (ns_si),
        .ns_ri       (ns_ri),
        .ns_di       (ns_di),
        .ns_so       (ns_so),
        .ns_ro       (ns_ro),
        .ns_do       (ns_do),
        .sn_pkt_cnt  (sn_pkt_cnt),
        .ns_pkt_cnt  (ns_pkt_cnt),
        .sn_drop_cnt (sn_drop_cnt),
        .ns_drop_cnt (ns_drop_cnt)
    );

    // ---------------- scoreboard / model ----------------
    logic [PW-1:0] sn_q[$];
    logic [PW-1:0] ns_q[$];
    logic          exp_so   [2];
    logic [PW-1:0] exp_do   [2];
    logic [CW-1:0] exp_pkt  [2];
    logic [CW-1:0] exp_drop [2];
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        sn_q.delete();
        ns_q.delete();
        for (int d = 0; d < 2; d++) begin
            exp_so[d]   = 1'b0;
            exp_do[d]   = '0;
            exp_pkt[d]  = '0;
            exp_drop[d] = '0;
        end
    endtask

    // One clock edge of one direction: deliver the oldest packet if the
    // receiver is ready, accept the new one if there was room before the edge.
    task automatic model_dir(input int d, input logic si, input logic ro, input logic [PW-1:0] di);
        int sz;
        bit room;
        sz   = (d == 0) ? sn_q.size() : ns_q.size();
        room = (sz < DEPTH);
        exp_so[d] = 1'b0;
        if (sz > 0 && ro) begin
            if (d == 0) exp_do[d] = sn_q.pop_front();
            else        exp_do[d] = ns_q.pop_front();
            exp_so[d]  = 1'b1;
            exp_pkt[d] = exp_pkt[d] + 1'b1;
        end
        if (si) begin
            if (room) begin
                if (d == 0) sn_q.push_back(di);
                else        ns_q.push_back(di);
            end else begin
                exp_drop[d] = exp_drop[d] + 1'b1;
            end
        end
    endtask

    task automatic check_all(input string ph);
        check({ph, ".sn_so"},  PW'(sn_so), PW'(exp_so[0]));
        check({ph, ".sn_do"},  sn_do, exp_do[0]);
        check({ph, ".sn_ri"},  PW'(sn_ri), PW'(sn_q.size() < DEPTH));
        check({ph, ".ns_so"},  PW'(ns_so), PW'(exp_so[1]));
        check({ph, ".ns_do"},  ns_do, exp_do[1]);
        check({ph, ".ns_ri"},  PW'(ns_ri), PW'(ns_q.size() < DEPTH));
        check({ph, ".sn_pkt"},  PW'(sn_pkt_cnt),  STATS ? PW'(exp_pkt[0])  : '0);
        check({ph, ".ns_pkt"},  PW'(ns_pkt_cnt),  STATS ? PW'(exp_pkt[1])  : '0);
        check({ph, ".sn_drop"}, PW'(sn_drop_cnt), STATS ? PW'(exp_drop[0]) : '0);
        check({ph, ".ns_drop"}, PW'(ns_drop_cnt), STATS ? PW'(exp_drop[1]) : '0);
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input string ph);
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            model_dir(0, sn_si, sn_ro, sn_di);
            model_dir(1, ns_si, ns_ro, ns_di);
        end
        #1;
        check_all(ph);
    endtask

    task automatic idle_inputs();
        sn_si = 1'b0;
        ns_si = 1'b0;
    endtask

    initial begin
        // Reset held two cycles: everything cleared, both sides ready.
        reset = 1'b1;
        cycle("reset");
        cycle("reset");
        reset = 1'b0;

        // Single packet: visible only one cycle after the pushing edge.
        sn_ro = 1'b1;
        sn_si = 1'b1;
        sn_di = 64'hA5A5_0000_0000_0001;
        cycle("single");
        idle_inputs();
        cycle("single");
        cycle("single");

        // Backpressure: two accepted, third dropped, then drained in order.
        sn_ro = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            sn_si = 1'b1;
            sn_di = PW'(i);
            cycle("bp_fill");
        end
        idle_inputs();
        sn_ro = 1'b1;
        for (int i = 0; i < 3; i++) cycle("bp_drain");

        // Streaming: 8 back-to-back packets, ready never drops.
        ns_ro = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ns_si = 1'b1;
            ns_di = 64'h10 + PW'(i);
            cycle("stream");
        end
        idle_inputs();
        for (int i = 0; i < 2; i++) cycle("stream_tail");

        // Independence: SN held full while NS streams.
        sn_ro = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sn_si = 1'b1;
            sn_di = 64'hBEEF_0000 + PW'(i);
            cycle("indep_fill");
        end
        sn_si = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ns_si = 1'b1;
            ns_di = 64'h20 + PW'(i);
            cycle("indep_ns");
        end
        idle_inputs();
        cycle("indep_ns");
        sn_ro = 1'b1;
        for (int i = 0; i < 3; i++) cycle("indep_sn");

        // Mid-operation reset with both FIFOs full: stored packets are lost.
        sn_ro = 1'b0;
        ns_ro = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sn_si = 1'b1;
            sn_di = 64'hC0 + PW'(i);
            ns_si = 1'b1;
            ns_di = 64'hD0 + PW'(i);
            cycle("midrst_fill");
        end
        idle_inputs();
        reset = 1'b1;
        cycle("midrst");
        reset = 1'b0;
        sn_ro = 1'b1;
        ns_ro = 1'b1;
        for (int i = 0; i < 3; i++) cycle("midrst_after");

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            sn_si = ($urandom_range(0, 2) != 0);
            ns_si = ($urandom_range(0, 2) != 0);
            sn_ro = ($urandom_range(0, 3) != 0);
            ns_ro = ($urandom_range(0, 1) != 0);
            sn_di = {$urandom, $urandom};
            ns_di = {$urandom, $urandom};
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
